btn_conditioner: RTL
====================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter `DEB_CYCLES`, default 500000: the number of consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter `CNT_W`, default 20: the width of the debounce counter, which must hold `DEB_CYCLES-1`.
REQ-003 SHALL have parameter `ACTIVE_LOW`, default 1: when 1, a raw input of 0 means pressed.
REQ-004 SHALL have parameter `REPEAT_DELAY`, default 25000000: cycles held in PRESSED before the first auto-repeat pulse.
REQ-005 SHALL have parameter `REPEAT_PERIOD`, default 5000000: cycles between subsequent auto-repeat pulses.
REQ-006 SHALL have port `i_clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port `i_rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port `i_btn_raw`, input, 1 bit: raw asynchronous pushbutton pin.
REQ-009 SHALL have port `o_btn_posedge`, output, 1 bit: one-cycle pulse per accepted press, registered.
REQ-010 SHALL have port `o_btn_negedge`, output, 1 bit: one-cycle pulse per accepted release, registered.
REQ-011 SHALL have port `o_btn_level`, output, 1 bit: debounced pressed level, active-high, registered.

Function
REQ-012 SHALL pass `i_btn_raw` through a 2-flop synchronizer, then invert it if `ACTIVE_LOW`=1, producing internal `s` (1 = pressed).
REQ-013 SHALL implement FSM states IDLE, DB_PRESS, PRESSED and DB_RELEASE, with the counter `cnt` `CNT_W` bits wide.
REQ-014 SHALL, in IDLE with `s`=1, go to DB_PRESS with `cnt`=0; otherwise it stays in IDLE.
REQ-015 SHALL, in DB_PRESS with `s`=0, return to IDLE with `cnt`=0 and no pulse (glitch rejected).
REQ-016 SHALL, in DB_PRESS with `s`=1 and `cnt`==`DEB_CYCLES-1`, go to PRESSED, set `o_btn_level`=1 and pulse `o_btn_posedge` for exactly one cycle; otherwise `cnt` increments.
REQ-017 SHALL, in PRESSED with `s`=0, go to DB_RELEASE with `cnt`=0.
REQ-018 SHALL, in DB_RELEASE with `s`=1, return to PRESSED with no pulse and `o_btn_level` still 1.
REQ-019 SHALL, in DB_RELEASE with `cnt`==`DEB_CYCLES-1` and `s`=0, go to IDLE, clear `o_btn_level` and pulse `o_btn_negedge` for one cycle.
REQ-020 SHALL give a latency such that, with the raw input stable and the sampling edge that first captures the new level counted as edge 0, the pulse or level change is registered at edge `DEB_CYCLES+2`.
REQ-021 SHALL never assert `o_btn_posedge` and `o_btn_negedge` in the same cycle, and SHALL never assert `o_btn_negedge` without a prior `o_btn_posedge`.
REQ-022 SHALL treat `DEB_CYCLES` < 2 as illegal; the module is not required to handle it.

Reset
REQ-023 SHALL, while `i_rst`=1, immediately force the FSM to IDLE and clear both synchronizer flops to the not-pressed level, clear all counters, and drive `o_btn_posedge`, `o_btn_negedge` and `o_btn_level` to 0.
REQ-024 SHALL, when reset asserts mid-press, emit no `o_btn_negedge`.
REQ-025 SHALL, when the button is held through reset release, treat it as a new press, with `o_btn_posedge` following after a full debounce.

Configuration
REQ-026 SHALL, with macro `BTN_REPEAT_EN` defined, keep a repeat counter that runs only in PRESSED and is cleared on entry to PRESSED from DB_PRESS or DB_RELEASE.
REQ-027 SHALL, with `BTN_REPEAT_EN` defined, pulse `o_btn_posedge` once more after `REPEAT_DELAY` cycles in PRESSED, then every `REPEAT_PERIOD` cycles until PRESSED is left.
REQ-028 SHALL, without `BTN_REPEAT_EN`, emit exactly one `o_btn_posedge` per accepted press, with no repeat logic synthesized and the `REPEAT_*` parameters ignored.

Verification (`DEB_CYCLES`=4, `ACTIVE_LOW`=1, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3)
REQ-029 SHALL cover a clean press: raw 1->0 held 20 cycles -> one `o_btn_posedge` registered at edge 6 and `o_btn_level`=1 from the same edge.
REQ-030 SHALL cover a glitch: raw low for 3 cycles, then high -> no pulse and `o_btn_level` stays 0.
REQ-031 SHALL cover release bounce: while pressed, raw high 2 cycles, low 2 cycles, then high 20 cycles -> exactly one `o_btn_negedge`, registered at edge 6 after the final rise.
REQ-032 SHALL cover reset mid-press: assert `i_rst` while `o_btn_level`=1 -> all outputs 0 immediately and no `o_btn_negedge`; raw still low at release -> new `o_btn_posedge` at edge 6 after release.
REQ-033 SHALL cover repeat with `BTN_REPEAT_EN`: hold 30 cycles after acceptance -> posedge pulses at acceptance and at +10, +13, +16, ... +28.
REQ-034 SHALL cover the same 30-cycle hold without `BTN_REPEAT_EN` -> a single posedge pulse only.

Source files
------------

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop sync, debounce FSM, registered press/release pulses and level.
// Latency: DEB_CYCLES+2 clocks from the edge that first samples a new raw level; no backpressure.
// Optional auto-repeat of o_btn_posedge while held is enabled by defining BTN_REPEAT_EN.
module btn_conditioner #(
    parameter int DEB_CYCLES    = 500000,
    parameter int CNT_W         = 20,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_raw,
    output logic o_btn_posedge,
    output logic o_btn_negedge,
    output logic o_btn_level
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // Raw pin level that means "not pressed"; also the synchronizer reset value.
    localparam logic             IDLE_RAW = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sync1;
    logic             sync2;
    logic             s;
    logic             level_nxt;
    logic             fsm_pos;
    logic             neg_nxt;
    logic             rpt_pulse;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= i_btn_raw;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ IDLE_RAW;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = o_btn_level;
        fsm_pos   = 1'b0;
        neg_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = DB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    fsm_pos   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_nxt = DB_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            DB_RELEASE: begin
                if (s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    neg_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic             rpt_periodic;
    logic             rpt_periodic_nxt;

    // First pulse after REPEAT_DELAY held cycles, then one every REPEAT_PERIOD.
    always_comb begin
        rpt_cnt_nxt      = rpt_cnt;
        rpt_periodic_nxt = rpt_periodic;
        rpt_pulse        = 1'b0;
        if (state != PRESSED && state_nxt == PRESSED) begin
            rpt_cnt_nxt      = '0;
            rpt_periodic_nxt = 1'b0;
        end else if (state == PRESSED && s) begin
            if (rpt_cnt == (rpt_periodic ? PER_LAST : DLY_LAST)) begin
                rpt_pulse        = 1'b1;
                rpt_cnt_nxt      = '0;
                rpt_periodic_nxt = 1'b1;
            end else begin
                rpt_cnt_nxt = rpt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b0;
        end else begin
            rpt_cnt      <= rpt_cnt_nxt;
            rpt_periodic <= rpt_periodic_nxt;
        end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            o_btn_level   <= 1'b0;
            o_btn_posedge <= 1'b0;
            o_btn_negedge <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            o_btn_level   <= level_nxt;
            o_btn_posedge <= fsm_pos | rpt_pulse;
            o_btn_negedge <= neg_nxt;
        end
    end

endmodule
